// File: rtl/can_pkg.sv
// can_pkg: state encoding, CRC-15 constants and field lengths shared by the
// CAN frame encoder and its bit stuffer.
package can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } can_state_e;

    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int          EOF_LEN    = 7;
    localparam int          IFS_LEN    = 3;
    localparam int          STUFF_RUN  = 5;

    // One serial CRC-15 step: shift in bit b, MSB-first polynomial division.
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb         = b ^ crc[14];
        crc15_step = {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
    endfunction

endpackage

// File: rtl/can_tx_stuffer.sv
// can_tx_stuffer: inserts a complement bit after STUFF_RUN equal bus bits and
// accumulates CRC-15 over the unstuffed bits. Stuff bits neither feed the CRC
// nor let the encoder advance its field position (stuff_o tells it to hold).
module can_tx_stuffer
    import can_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,       // frame accepted: restart CRC and run count
    input  logic        adv_i,       // a bus bit is emitted on this edge
    input  logic        bit_i,       // next unstuffed field bit
    input  logic        stuff_en_i,  // bit_i lies in SOF..CRC
    input  logic        crc_en_i,    // bit_i lies in SOF..last data bit
    output logic        stuff_o,     // this edge emits a stuff bit instead of bit_i
    output logic        tx_bit_o,
    output logic [14:0] crc_o
);

    logic [14:0] crc_q, crc_d;
    logic [2:0]  run_q, run_d;
    logic        last_q, last_d;

    assign stuff_o  = (run_q == 3'(STUFF_RUN));
    assign tx_bit_o = stuff_o ? ~last_q : bit_i;
    assign crc_o    = crc_q;

    // Run-length and CRC update for the bit leaving on this edge.
    always_comb begin
        crc_d  = crc_q;
        run_d  = run_q;
        last_d = last_q;
        if (clr_i) begin
            crc_d  = '0;
            run_d  = '0;
            last_d = 1'b0;
        end else if (adv_i) begin
            if (stuff_o) begin
                // the stuff bit itself opens the next run
                last_d = ~last_q;
                run_d  = 3'd1;
            end else if (stuff_en_i) begin
                run_d  = (bit_i == last_q && run_q != 3'd0) ? run_q + 3'd1 : 3'd1;
                last_d = bit_i;
                if (crc_en_i) crc_d = crc15_step(crc_q, bit_i);
            end else begin
                run_d  = '0;
                last_d = bit_i;
            end
        end
    end

    // Stuffer and CRC state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q  <= '0;
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_frame_encoder.sv
// can_frame_encoder: serialises one CAN 2.0 data/remote frame (standard or
// extended) per start request, one bus bit per SP edge, and monitors RX for
// the ACK slot. Define CAN_ARB_MONITOR_EN to back off on arbitration loss.
//
// state_q/idx_q name the next unstuffed bit to emit; txst_q names the field of
// the bit currently on TX (a stuff bit inherits the field that caused it), so
// RX sampled on an edge is judged against the bit that was on the bus.
module can_frame_encoder
    import can_pkg::*;
(
    input  logic        SP,
    input  logic        reset,
    input  logic        start,
    input  logic        IDE,
    input  logic        RTR,
    input  logic [10:0] IDF,
    input  logic [17:0] IDF_ex,
    input  logic [3:0]  DLC,
    input  logic [63:0] DATA,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        done,
    output logic        arb_lost,
    output logic        ack_err
);

    can_state_e  state_q, state_d, txst_q, txst_d, next_st;
    logic [5:0]  idx_q, idx_d;
    logic        ide_q, rtr_q;
    logic [10:0] idf_q;
    logic [17:0] idfx_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic        tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic        arb_q, arb_d, ack_q, ack_d;
    logic        latch, clr, adv, arb_lose;

    logic        fbit, stuff_en, crc_en, last, stuff, tx_bit;
    logic [6:0]  flen, nbits;
    logic [3:0]  nbytes;
    logic [14:0] crc;
    logic [10:0] idf_sh;
    logic [17:0] idfx_sh;
    logic [3:0]  dlc_sh;
    logic [63:0] data_sh;
    logic [14:0] crc_sh;

    assign nbytes  = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
    assign nbits   = {nbytes, 3'b000};
    assign idf_sh  = idf_q << idx_q;
    assign idfx_sh = idfx_q << (idx_q - 6'd13);
    assign dlc_sh  = dlc_q << (idx_q - 6'd2);
    assign data_sh = data_q << idx_q;
    assign crc_sh  = crc << idx_q;
    assign last    = ({1'b0, idx_q} == flen - 7'd1);

`ifdef CAN_ARB_MONITOR_EN
    assign arb_lose = (txst_q == ST_ARB) && tx_q && !RX;
`else
    assign arb_lose = 1'b0;
`endif

    // Field bit, field length and region flags for the next unstuffed bit.
    always_comb begin
        fbit     = 1'b1;
        flen     = 7'd1;
        stuff_en = 1'b0;
        crc_en   = 1'b0;
        next_st  = ST_IDLE;
        case (state_q)
            ST_SOF: begin
                fbit = 1'b0; stuff_en = 1'b1; crc_en = 1'b1; next_st = ST_ARB;
            end
            ST_ARB: begin
                flen = ide_q ? 7'd32 : 7'd12;
                stuff_en = 1'b1; crc_en = 1'b1; next_st = ST_CTRL;
                if (idx_q < 6'd11)                 fbit = idf_sh[10];
                else if (!ide_q || idx_q == 6'd31) fbit = rtr_q;
                else if (idx_q < 6'd13)            fbit = 1'b1;   // SRR, IDE
                else                               fbit = idfx_sh[17];
            end
            ST_CTRL: begin
                // IDE/r1 and r0 are dominant, then DLC MSB first
                flen = 7'd6; stuff_en = 1'b1; crc_en = 1'b1;
                fbit = (idx_q < 6'd2) ? 1'b0 : dlc_sh[3];
                next_st = (nbytes == 4'd0) ? ST_CRC : ST_DATA;
            end
            ST_DATA: begin
                flen = nbits; fbit = data_sh[63];
                stuff_en = 1'b1; crc_en = 1'b1; next_st = ST_CRC;
            end
            ST_CRC: begin
                flen = 7'd15; fbit = crc_sh[14]; stuff_en = 1'b1; next_st = ST_CRC_DEL;
            end
            ST_CRC_DEL:  next_st = ST_ACK_SLOT;
            ST_ACK_SLOT: next_st = ST_ACK_DEL;
            ST_ACK_DEL:  next_st = ST_EOF;
            ST_EOF: begin
                flen = 7'(EOF_LEN); next_st = ST_IFS;
            end
            ST_IFS: begin
                flen = 7'(IFS_LEN); next_st = ST_IDLE;
            end
            default: ;
        endcase
    end

    // Frame sequencing: accept start, emit one bit per edge, handle aborts.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        txst_d  = txst_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        latch   = 1'b0;
        clr     = 1'b0;
        adv     = 1'b0;
        arb_d   = 1'b0;
        done_d  = busy_q && (state_q == ST_IDLE) && (txst_q == ST_IFS);
        ack_d   = (txst_q == ST_ACK_SLOT) && RX;
        if (state_q == ST_IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            txst_d = ST_IDLE;
            // busy_q still covers the last IFS bit, so a start there is ignored
            if (start && !busy_q) begin
                latch   = 1'b1;
                clr     = 1'b1;
                state_d = ST_SOF;
                idx_d   = '0;
            end
        end else if (arb_lose) begin
            arb_d   = 1'b1;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            txst_d  = ST_IDLE;
            idx_d   = '0;
        end else begin
            adv    = 1'b1;
            busy_d = 1'b1;
            tx_d   = tx_bit;
            if (!stuff) begin
                txst_d = state_q;
                if (last) begin
                    idx_d   = '0;
                    state_d = next_st;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
        end
    end

    // FSM, latched request fields and registered outputs.
    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            txst_q  <= ST_IDLE;
            idx_q   <= '0;
            ide_q   <= 1'b0;
            rtr_q   <= 1'b0;
            idf_q   <= '0;
            idfx_q  <= '0;
            dlc_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            arb_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txst_q  <= txst_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            arb_q   <= arb_d;
            ack_q   <= ack_d;
            if (latch) begin
                ide_q  <= IDE;
                rtr_q  <= RTR;
                idf_q  <= IDF;
                idfx_q <= IDF_ex;
                dlc_q  <= DLC;
                data_q <= DATA;
            end
        end
    end

    can_tx_stuffer u_stuffer (
        .clk_i      (SP),
        .rst_ni     (reset),
        .clr_i      (clr),
        .adv_i      (adv),
        .bit_i      (fbit),
        .stuff_en_i (stuff_en),
        .crc_en_i   (crc_en),
        .stuff_o    (stuff),
        .tx_bit_o   (tx_bit),
        .crc_o      (crc)
    );

    assign TX       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign arb_lost = arb_q;
    assign ack_err  = ack_q;

endmodule

// File: tb/tb_can_frame_encoder.sv
// Testbench for can_frame_encoder: a reference model pushes the expected
// stuffed bus bits of each frame into a queue; they are popped and compared
// bit by bit while busy is high.
module tb_can_frame_encoder;

    logic        SP = 1'b0;
    logic        reset, start, IDE, RTR, RX;
    logic [10:0] IDF;
    logic [17:0] IDF_ex;
    logic [3:0]  DLC;
    logic [63:0] DATA;
    logic        TX, busy, done, arb_lost, ack_err;

    int total = 0;
    int bad   = 0;
    bit sb[$];
    int ack_pos, data3_pos, exp_len;
    bit dut_bits[0:511];
    bit poke;
    bit ab;

    always #5 SP = ~SP;

    can_frame_encoder dut (
        .SP(SP), .reset(reset), .start(start), .IDE(IDE), .RTR(RTR),
        .IDF(IDF), .IDF_ex(IDF_ex), .DLC(DLC), .DATA(DATA), .RX(RX),
        .TX(TX), .busy(busy), .done(done), .arb_lost(arb_lost), .ack_err(ack_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: unstuffed SOF..CRC, stuffing, then the recessive tail.
    task automatic build_model(input bit ide, input bit rtr, input logic [10:0] idf,
                               input logic [17:0] idfx, input logic [3:0] dlc,
                               input logic [63:0] data);
        bit ub[$];
        int nb, d3u, run;
        bit lastb;
        logic [14:0] crc;
        sb.delete();
        d3u = -1;
        data3_pos = -1;
        ub.push_back(1'b0);
        for (int i = 10; i >= 0; i--) ub.push_back(idf[i]);
        if (ide) begin
            ub.push_back(1'b1);
            ub.push_back(1'b1);
            for (int i = 17; i >= 0; i--) ub.push_back(idfx[i]);
        end
        ub.push_back(rtr);
        ub.push_back(1'b0);
        ub.push_back(1'b0);
        for (int i = 3; i >= 0; i--) ub.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 8 * nb; i++) begin
            if (i == 3) d3u = ub.size();
            ub.push_back(data[63 - i]);
        end
        crc = 15'h0;
        foreach (ub[k]) begin
            if (ub[k] ^ crc[14]) crc = {crc[13:0], 1'b0} ^ 15'h4599;
            else                 crc = {crc[13:0], 1'b0};
        end
        for (int i = 14; i >= 0; i--) ub.push_back(crc[i]);
        run = 0;
        lastb = 1'b0;
        foreach (ub[k]) begin
            if (k == d3u) data3_pos = sb.size();
            sb.push_back(ub[k]);
            if (run > 0 && ub[k] == lastb) run++;
            else run = 1;
            lastb = ub[k];
            if (run == 5) begin
                lastb = ~lastb;
                sb.push_back(lastb);
                run = 1;
            end
        end
        sb.push_back(1'b1);                 // CRC delimiter
        ack_pos = sb.size();
        repeat (2 + 7 + 3) sb.push_back(1'b1);
        exp_len = sb.size();
    endtask

    task automatic begin_frame(input bit ide, input bit rtr, input logic [10:0] idf,
                               input logic [17:0] idfx, input logic [3:0] dlc,
                               input logic [63:0] data);
        build_model(ide, rtr, idf, idfx, dlc, data);
        @(negedge SP);
        IDE = ide; RTR = rtr; IDF = idf; IDF_ex = idfx; DLC = dlc; DATA = data;
        start = 1'b1;
        @(negedge SP);
        start = 1'b0;
        chk("pre_sof_tx", TX, 1);
        chk("pre_sof_busy", busy, 0);
    endtask

    // Compare each bus bit against the queue; drive RX as the bus would.
    task automatic run_frame(input int fpos, input bit fval, input bit all1,
                             input int abort_at, output bit aborted);
        int pos = 0;
        bit ended = 1'b0;
        logic expb;
        aborted = 1'b0;
        for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
            @(negedge SP);
            if (!busy) begin
                ended = 1'b1;
            end else begin
                expb = (sb.size() > 0) ? sb.pop_front() : 1'bx;
                chk($sformatf("tx_bit%0d", pos), TX, expb);
                chk($sformatf("ack_err_bit%0d", pos), ack_err, (pos == ack_pos + 1) && all1);
                chk($sformatf("arb_lost_bit%0d", pos), arb_lost, 0);
                chk($sformatf("done_bit%0d", pos), done, 0);
                if (pos < 512) dut_bits[pos] = TX;
                if (pos == abort_at) begin
                    aborted = 1'b1;
                    return;
                end
                if (poke && pos == 10) begin
                    start = 1'b1; IDF = ~IDF; DATA = ~DATA; DLC = ~DLC;
                end
                if (poke && pos == 11) start = 1'b0;
                if (all1)                RX = 1'b1;
                else if (pos == ack_pos) RX = 1'b0;
                else if (pos == fpos)    RX = fval;
                else                     RX = TX;
                pos++;
            end
        end
        if (!ended) chk("frame_timeout", 1, 0);
        chk("frame_len", pos, exp_len);
        chk("done_pulse", done, 1);
        chk("tx_idle", TX, 1);
        chk("sb_empty", sb.size(), 0);
        RX = 1'b1;
        @(negedge SP);
        chk("done_clear", done, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; RX = 1'b1; poke = 1'b0;
        IDE = 0; RTR = 0; IDF = '0; IDF_ex = '0; DLC = '0; DATA = '0;
        #3 reset = 1'b0;
        @(negedge SP);
        @(negedge SP);
        chk("rst_tx", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_arb", arb_lost, 0);
        chk("rst_ack", ack_err, 0);
        reset = 1'b1;

        // standard data frame, one byte, ACK given
        begin_frame(0, 0, 11'h123, 18'h0, 4'd1, 64'hAA00_0000_0000_0000);
        run_frame(-1, 0, 0, -1, ab);

        // standard remote frame with all-zero ID: stuff after SOF + 4 zeros
        begin_frame(0, 1, 11'h000, 18'h0, 4'd0, 64'h0);
        run_frame(-1, 0, 0, -1, ab);
        for (int i = 0; i < 5; i++) chk($sformatf("rtr_zero%0d", i), dut_bits[i], 0);
        chk("rtr_stuff5", dut_bits[5], 1);
        chk("rtr_after_stuff", dut_bits[6], 0);

        // extended frame, all-ones IDs, eight zero bytes
        begin_frame(1, 0, 11'h7FF, 18'h3FFFF, 4'd8, 64'h0);
        run_frame(-1, 0, 0, -1, ab);

        // no ACK (RX recessive throughout), start/fields poked mid-frame
        poke = 1'b1;
        begin_frame(0, 0, 11'h555, 18'h0, 4'd2, 64'h1234_0000_0000_0000);
        run_frame(-1, 0, 1, -1, ab);
        poke = 1'b0;

        // DLC above 8 clamps to eight bytes
        begin_frame(0, 0, 11'h2A5, 18'h0, 4'd9, 64'hDEAD_BEEF_0123_4567);
        run_frame(-1, 0, 0, -1, ab);

`ifdef CAN_ARB_MONITOR_EN
        begin_frame(0, 0, 11'h400, 18'h0, 4'd1, 64'h5500_0000_0000_0000);
        @(negedge SP);
        chk("arb_sof", TX, 0);
        RX = 1'b0;
        @(negedge SP);
        chk("arb_id10", TX, 1);
        RX = 1'b0;
        @(negedge SP);
        chk("arb_lost_pulse", arb_lost, 1);
        chk("arb_tx", TX, 1);
        chk("arb_busy", busy, 0);
        RX = 1'b1;
        @(negedge SP);
        chk("arb_lost_clear", arb_lost, 0);
        chk("arb_no_done", done, 0);
        chk("arb_still_idle", busy, 0);
        sb.delete();
`else
        // RX dominant under a recessive ID bit is not monitored in this build
        begin_frame(0, 0, 11'h400, 18'h0, 4'd1, 64'h5500_0000_0000_0000);
        run_frame(1, 0, 0, -1, ab);
`endif

        // reset during DATA bit 3, then a fresh frame
        begin_frame(0, 0, 11'h0F0, 18'h0, 4'd4, 64'h0123_4567_89AB_CDEF);
        run_frame(-1, 0, 0, data3_pos, ab);
        chk("abort_reached", ab, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx", TX, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        sb.delete();
        RX = 1'b1;
        @(negedge SP);
        @(negedge SP);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge SP);
            chk($sformatf("post_rst_done%0d", i), done, 0);
            chk($sformatf("post_rst_tx%0d", i), TX, 1);
        end
        begin_frame(0, 0, 11'h3C1, 18'h0, 4'd3, 64'hF00F_5A00_0000_0000);
        run_frame(-1, 0, 0, -1, ab);
        chk("restart_sof", dut_bits[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
